ieee_div: RTL and testbench

Sequential IEEE-754 single-precision divider computing `a / b` with a restoring radix-2 mantissa divider, one quotient bit per clock. It is the inverse-operation companion to the combinational `ieee_mult` in the floating-point unit, and follows the same numeric conventions: truncation, denormals flushed to zero, and a single canonical pattern for NaN and infinity. A start/done handshake lets a controller issue one division at a time and collect the registered result.

---
 rtl/ieee_div_pkg.sv | 24 ++
 rtl/ieee_div_mant_div_step.sv | 17 +
 rtl/ieee_div.sv | 124 ++++++++++++
 tb/tb_ieee_div.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ieee_div_pkg.sv
// Shared constants, state encoding and field-split helper for the IEEE-754 divider.
package ieee_div_pkg;

  localparam int BIAS = 127;
  localparam logic [31:0] INF_NAN = 32'h7F800000;
  localparam int ITER_DEF = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp_t;

  function automatic fp_t split(input logic [31:0] x);
    return fp_t'(x);
  endfunction

endpackage

// File: rtl/ieee_div_mant_div_step.sv
// One restoring radix-2 division iteration: conditional subtract, then shift left.
module mant_div_step (
  input  logic [24:0] rem,
  input  logic [23:0] mb,
  output logic [24:0] rem_next,
  output logic        qbit
);

  logic [24:0] rem_sub;

  always_comb begin
    qbit     = (rem >= {1'b0, mb});
    rem_sub  = qbit ? (rem - {1'b0, mb}) : rem;
    rem_next = {rem_sub[23:0], 1'b0};
  end

endmodule

// File: rtl/ieee_div.sv
// Sequential single-precision divider: one quotient bit per clock, truncating,
// denormals flushed to zero, canonical pattern for NaN/infinity.
module ieee_div
  import ieee_div_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output state_t      state_dbg
);

  // Handshake: start is sampled only in IDLE; busy is high from the accepting
  // edge until done rises; done is a one-cycle pulse and out is valid with it.

  localparam int CW = $clog2(ITER);

  state_t      state, state_next;
  logic [CW-1:0] cnt;
  logic [24:0] rem, q;
  logic [23:0] mb_r;
  logic [7:0]  ea_r, eb_r;
  logic        s_r, spec_r;
  logic [31:0] spec_val_r;

  fp_t         fa, fb;
  logic        spec_inf, spec_zero, spec_any;
  logic [24:0] step_rem;
  logic        step_qbit;

  logic [9:0]        bias_adj;
  logic signed [9:0] e_calc;
  logic [22:0]       mant;
  logic [31:0]       norm_res;

  assign fa        = split(a);
  assign fb        = split(b);
  assign spec_inf  = (fa.exp == 8'hFF) || (fb.exp == 8'hFF) || (fb.exp == 8'h00);
  assign spec_zero = (fa.exp == 8'h00);
  assign spec_any  = spec_inf || spec_zero;

  mant_div_step u_step (
    .rem      (rem),
    .mb       (mb_r),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = spec_any ? DONE : CALC;
      CALC:    if (cnt == CW'(ITER - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Integer quotient bit set means the mantissa ratio is in [1,2).
  always_comb begin
    bias_adj = q[24] ? 10'(BIAS) : 10'(BIAS - 1);
    e_calc   = signed'(10'({2'b00, ea_r}) - 10'({2'b00, eb_r}) + bias_adj);
    mant     = q[24] ? q[23:1] : q[22:0];
    if (e_calc >= 10'sd255)
      norm_res = {s_r, 8'hFF, 23'd0};
    else if (e_calc <= 10'sd0)
      norm_res = {s_r, 8'h00, 23'd0};
    else
      norm_res = {s_r, e_calc[7:0], mant};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      q          <= '0;
      mb_r       <= '0;
      ea_r       <= '0;
      eb_r       <= '0;
      s_r        <= 1'b0;
      spec_r     <= 1'b0;
      spec_val_r <= '0;
      out        <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt        <= '0;
          rem        <= {1'b0, 1'b1, fa.frac};
          q          <= '0;
          mb_r       <= {1'b1, fb.frac};
          ea_r       <= fa.exp;
          eb_r       <= fb.exp;
          s_r        <= fa.sign ^ fb.sign;
          spec_r     <= spec_any;
          spec_val_r <= spec_inf ? INF_NAN : 32'h0;
        end
        CALC: begin
          rem <= step_rem;
          q   <= {q[23:0], step_qbit};
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          out  <= spec_r ? spec_val_r : norm_res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_ieee_div.sv
// Directed self-checking bench for ieee_div: values, latency, handshake and reset abort.
module tb_ieee_div;
  import ieee_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] dout;
  state_t      state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  ieee_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .out       (dout),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one division and check busy, latency, result and pulse width.
  // If inj > 0, a second start with operands ia/ib is pulsed at edge T<inj>.
  task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp, input int lat,
                         input int inj, input logic [31:0] ia, input logic [31:0] ib);
    int n;
    bit got;
    logic [31:0] exp_v;
    exp_q.push_back(exp);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      if (inj > 0 && n == inj - 1) begin
        a = ia; b = ib; start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) got = 1'b1;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    exp_v = exp_q.pop_front();
    check(tag, dout, exp_v);
    @(posedge clk);
    #1 check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", dout, 32'h0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    run_div("one_div_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 26, 0, 0, 0);
    run_div("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, 26, 0, 0, 0);
    run_div("neg_six_div_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 26, 0, 0, 0);
    run_div("one_div_two", 32'h3F800000, 32'h40000000, 32'h3F000000, 26, 0, 0, 0);
    run_div("one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26, 0, 0, 0);
    run_div("div_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, 0, 0);
    run_div("nan_in", 32'h7FC00000, 32'h3F800000, 32'h7F800000, 1, 0, 0, 0);
    run_div("zero_num", 32'h00000000, 32'h3F800000, 32'h00000000, 1, 0, 0, 0);
    run_div("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 26, 0, 0, 0);
    run_div("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 26, 0, 0, 0);
    run_div("start_ignored", 32'h40C00000, 32'h40000000, 32'h40400000, 26, 10,
            32'h3F800000, 32'h40400000);

    // Reset at T12 aborts the division.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out", dout, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_div("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 26, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
